// File: rtl/loader_pkg.sv
// loader_pkg: shared constants and state encoding for the boot-time memory loader.
// The checksum state is only reachable when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  localparam int WORD_SIZE_DEFAULT = 20;
  localparam int MEM_SIZE_DEFAULT  = 4096;
  localparam int BYTES_PER_WORD    = 3;
  localparam int INDEX_W           = 16;

  typedef enum logic [3:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  // States in which the loader is willing to take a byte from the receiver.
  function automatic logic accepts_byte(input state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_B0) ||
           (s == ST_B1) || (s == ST_B2) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// word_assembler: collects the three bytes of a memory word, most significant first.
// Only the low 12 bits of history are kept: after B0 and B1 that is {B0[3:0], B1},
// so the discarded B0 high nibble simply falls off the top of the register.
// word presents the finished word assuming byte_in is the final byte (B2), which lets
// the loader register the write data on the same edge that accepts B2.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [19:0] word,
  output logic [1:0]  count
);

  logic [11:0] shift_reg;
  logic [1:0]  count_reg;

  // Shift accepted bytes in and track how many of the current word have arrived.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_reg <= '0;
      count_reg <= '0;
    end else if (byte_valid) begin
      shift_reg <= {shift_reg[3:0], byte_in};
      count_reg <= count_reg + 2'd1;
    end
  end

  assign word  = {shift_reg, byte_in};
  assign count = count_reg;

endmodule

// File: rtl/memory_loader.sv
// memory_loader: boot loader that turns a framed byte stream into sequential memory
// writes from address 0, holding the processor in reset until the image is complete.
// Frame: LEN_HI, LEN_LO, then N words of 3 bytes, then an optional checksum byte.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the trailing checksum byte check).
module memory_loader
  import loader_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEFAULT,
  parameter int MEM_SIZE  = MEM_SIZE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  output logic [WORD_SIZE-1:0] addr_o,
  output logic [WORD_SIZE-1:0] value_o,
  output logic                 write_o,
  output logic                 cpu_reset_o,
  output logic                 done_o,
  output logic                 error_o
);

  state_t               state_reg;
  logic [7:0]           len_hi_reg;
  logic [INDEX_W-1:0]   len_reg;
  logic [INDEX_W-1:0]   index_reg;
  logic [INDEX_W-1:0]   index_next;
  logic [WORD_SIZE-1:0] addr_reg;
  logic [WORD_SIZE-1:0] value_reg;
  logic                 write_reg;
  logic                 cpu_reset_reg;
  logic                 done_reg;
  logic                 error_reg;

  logic                 accept;
  logic                 word_byte;
  logic [INDEX_W-1:0]   length_word;
  logic                 length_bad;
  logic [19:0]          asm_word;
  logic [1:0]           asm_count;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           csum_reg;
  logic [7:0]           csum_total;
  assign csum_total = csum_reg + rx_data_i;
`endif

  // Ready depends on state only, so rx_valid_i never feeds back into rx_ready_o.
  assign rx_ready_o  = accepts_byte(state_reg);
  assign accept      = rx_valid_i && rx_ready_o;
  assign word_byte   = accept && ((state_reg == ST_B0) || (state_reg == ST_B1) ||
                                  (state_reg == ST_B2));
  assign length_word = {len_hi_reg, rx_data_i};
  assign length_bad  = (length_word == '0) || (32'(length_word) > 32'(MEM_SIZE));
  assign index_next  = index_reg + 16'd1;

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (state_reg == ST_WRITE),
    .byte_valid (word_byte),
    .byte_in    (rx_data_i),
    .word       (asm_word),
    .count      (asm_count)
  );

  // Frame FSM with word index, checksum and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_LEN_HI;
      len_hi_reg    <= '0;
      len_reg       <= '0;
      index_reg     <= '0;
      addr_reg      <= '0;
      value_reg     <= '0;
      write_reg     <= 1'b0;
      cpu_reset_reg <= 1'b1;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_reg      <= '0;
`endif
    end else begin
      write_reg <= 1'b0;
      case (state_reg)
        ST_LEN_HI: begin
          if (accept) begin
            len_hi_reg <= rx_data_i;
            state_reg  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            if (length_bad) begin
              state_reg <= ST_ERROR;
              error_reg <= 1'b1;
            end else begin
              len_reg   <= length_word;
              state_reg <= ST_B0;
            end
          end
        end
        ST_B0, ST_B1, ST_B2: begin
          if (accept) begin
`ifdef LOADER_CHECKSUM_EN
            csum_reg <= csum_total;
`endif
            if (asm_count == 2'(BYTES_PER_WORD - 1)) begin
              // Final byte of the word: present the write during the WRITE cycle.
              state_reg <= ST_WRITE;
              write_reg <= 1'b1;
              addr_reg  <= WORD_SIZE'(index_reg);
              value_reg <= WORD_SIZE'(asm_word);
            end else if (state_reg == ST_B0) begin
              state_reg <= ST_B1;
            end else begin
              state_reg <= ST_B2;
            end
          end
        end
        ST_WRITE: begin
          index_reg <= index_next;
          if (index_next == len_reg) begin
`ifdef LOADER_CHECKSUM_EN
            state_reg     <= ST_CHECK;
`else
            state_reg     <= ST_DONE;
            done_reg      <= 1'b1;
            cpu_reset_reg <= 1'b0;
`endif
          end else begin
            state_reg <= ST_B0;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) begin
            if (csum_total == 8'd0) begin
              state_reg     <= ST_DONE;
              done_reg      <= 1'b1;
              cpu_reset_reg <= 1'b0;
            end else begin
              state_reg <= ST_ERROR;
              error_reg <= 1'b1;
            end
          end
        end
`endif
        default: begin
          // DONE and ERROR hold until reset.
        end
      endcase
    end
  end

  assign addr_o      = addr_reg;
  assign value_o     = value_reg;
  assign write_o     = write_reg;
  assign cpu_reset_o = cpu_reset_reg;
  assign done_o      = done_reg;
  assign error_o     = error_reg;

endmodule
